seg_disp_ctrl: RTL

//  Owns the 32-bit seg_data word feeding scan_seg; shares the 8-digit display between two requesters.
//  CPU MMIO writes (cpu_*) are the normal owner. System/status events (sys_*, e.g. exception code)
//  pre-empt the CPU for a fixed hold window. When the window ends, the last CPU value is restored.

---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_hold_timer.sv | 24 ++
 rtl/seg_disp_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for the seg_disp_ctrl display arbiter
package seg_pkg;
  localparam int SEG_W  = 32;
  localparam int DIGITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_SYS  = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_SYS  = 2'd2;

  function automatic logic [1:0] owner_of(input state_t s);
    case (s)
      ST_CPU:  return OWN_CPU;
      ST_SYS:  return OWN_SYS;
      default: return OWN_NONE;
    endcase
  endfunction
endpackage

// File: rtl/seg_hold_timer.sv
// rtl/seg_hold_timer.sv - loadable down-counter that parks at zero and flags expiry
module seg_hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);
endmodule

// File: rtl/seg_disp_ctrl.sv
// rtl/seg_disp_ctrl.sv - arbitrates the 8-digit display word between CPU writes and timed system holds
// Optional blinking of the display during a system hold is built when BLINK_EN is defined.
module seg_disp_ctrl
  import seg_pkg::*;
#(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int BLINK_HALF  = 25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [SEG_W-1:0]  cpu_data,
  output logic              cpu_ack,
  input  logic              sys_req,
  input  logic [SEG_W-1:0]  sys_data,
  output logic              sys_ack,
  input  logic              clear,
  output logic [SEG_W-1:0]  seg_data,
  output logic [DIGITS-1:0] seg_blank,
  output logic [1:0]        owner,
  output logic              busy
);
  localparam int HW = $clog2(HOLD_CYCLES);

  if (HOLD_CYCLES < 2 || BLINK_HALF < 1) begin : g_bad_param
    $error("seg_disp_ctrl: HOLD_CYCLES must be >= 2 and BLINK_HALF >= 1");
  end

  state_t           state;
  state_t           state_next;
  logic [SEG_W-1:0] shadow;
  logic             shadow_valid;
  logic [SEG_W-1:0] seg_data_next;
  logic [SEG_W-1:0] shadow_next;
  logic             shadow_valid_next;
  logic             sys_acc;
  logic             cpu_acc;
  logic             hold_exit;
  logic             hold_expire;
  logic             hold_load;
  logic [HW-1:0]    hold_load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A request is not re-taken in its own ack cycle; the CPU is locked out for the whole hold.
  always_comb begin
    sys_acc    = !clear && sys_req && !sys_ack;
    cpu_acc    = !clear && !sys_acc && cpu_req && !cpu_ack && (state != ST_SYS);
    hold_exit  = !clear && !sys_acc && (state == ST_SYS) && hold_expire;
    state_next = state;
    if (clear) begin
      state_next = ST_IDLE;
    end else if (sys_acc) begin
      state_next = ST_SYS;
    end else if (cpu_acc) begin
      state_next = ST_CPU;
    end else if (hold_exit) begin
      state_next = shadow_valid ? ST_CPU : ST_IDLE;
    end
  end

  always_comb begin
    seg_data_next     = seg_data;
    shadow_next       = shadow;
    shadow_valid_next = shadow_valid;
    if (clear) begin
      seg_data_next     = '0;
      shadow_next       = '0;
      shadow_valid_next = 1'b0;
    end else if (sys_acc) begin
      seg_data_next = sys_data;
    end else if (cpu_acc) begin
      seg_data_next     = cpu_data;
      shadow_next       = cpu_data;
      shadow_valid_next = 1'b1;
    end else if (hold_exit) begin
      seg_data_next = shadow_valid ? shadow : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_data     <= '0;
      shadow       <= '0;
      shadow_valid <= 1'b0;
      cpu_ack      <= 1'b0;
      sys_ack      <= 1'b0;
      owner        <= OWN_NONE;
      busy         <= 1'b0;
    end else begin
      seg_data     <= seg_data_next;
      shadow       <= shadow_next;
      shadow_valid <= shadow_valid_next;
      cpu_ack      <= cpu_acc;
      sys_ack      <= sys_acc;
      owner        <= owner_of(state_next);
      busy         <= (state_next == ST_SYS);
    end
  end

  assign hold_load     = clear || sys_acc;
  assign hold_load_val = sys_acc ? HW'(HOLD_CYCLES - 1) : '0;

  seg_hold_timer #(.W(HW)) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (hold_load_val),
    .expire   (hold_expire)
  );

`ifdef BLINK_EN
  localparam int BW = $clog2(BLINK_HALF) + 1;

  logic blink_expire;
  logic blink_load;
  logic blink_stay;
  logic blank_on;

  // Toggling only while the hold continues; entry, reload and exit all return to lit.
  assign blink_stay = (state == ST_SYS) && (state_next == ST_SYS) && !sys_acc;
  assign blink_load = sys_acc || (blink_stay && blink_expire);

  seg_hold_timer #(.W(BW)) u_blink_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (blink_load),
    .load_val (BW'(BLINK_HALF - 1)),
    .expire   (blink_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_on <= 1'b0;
    end else if (sys_acc || state_next != ST_SYS) begin
      blank_on <= 1'b0;
    end else if (blink_stay && blink_expire) begin
      blank_on <= !blank_on;
    end
  end

  assign seg_blank = {DIGITS{blank_on}};
`else
  assign seg_blank = '0;
`endif
endmodule
